// File: rtl/cw_decoder_if.sv
// Signal bundle between the CW decoder and its tick/key source and character consumer.
interface cw_decoder_if;
  logic       do1k;
  logic       cw_key;
  logic [9:0] dot_time;
  logic       decode_en;
  logic [7:0] char_code;
  logic       char_valid;
  logic       busy;

  modport master (
    output do1k, cw_key, dot_time, decode_en,
    input  char_code, char_valid, busy
  );

  modport slave (
    input  do1k, cw_key, dot_time, decode_en,
    output char_code, char_valid, busy
  );
endinterface

// File: rtl/cw_decoder.sv
// CW receive decoder: times marks/spaces on 1 ms ticks, classifies dots/dashes
// and emits one ASCII byte per character plus a space on a word gap.
module cw_decoder #(
  parameter int GLITCH_MS = 5,
  parameter int CNT_W     = 13
) (
  input logic         IF_clk,
  input logic         rstb,
  cw_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GLITCH_T = CNT_W'(GLITCH_MS);

  state_t           state_reg, state_next;
  logic             key_meta_reg, key_s_reg;
  logic [CNT_W-1:0] mark_cnt_reg, mark_cnt_next;
  logic [CNT_W-1:0] space_cnt_reg, space_cnt_next;
  logic [5:0]       pattern_reg, pattern_next;
  logic [2:0]       count_reg, count_next;
  logic [7:0]       char_code_reg, emit_code;
  logic             char_valid_reg, emit;

  logic [CNT_W-1:0] dot_ext, dash_t, char_t, word_t, space_inc;
  logic             disabled;

  assign dot_ext   = CNT_W'(bus.dot_time);
  assign dash_t    = dot_ext << 1;
  assign char_t    = dot_ext << 1;
  assign word_t    = (dot_ext << 2) + dot_ext;
  assign disabled  = !bus.decode_en || (bus.dot_time == 10'd0);
  assign space_inc = (space_cnt_reg == CNT_MAX) ? space_cnt_reg : space_cnt_reg + CNT_W'(1);

  // Pattern holds elements oldest-first in the high bits; unused upper bits are zero.
  function automatic logic [7:0] lookup(input logic [2:0] cnt, input logic [5:0] pat);
    logic [7:0] code;
    code = 8'h3F;
    case ({cnt, pat})
      {3'd1, 6'b000000}: code = 8'h45; // E
      {3'd1, 6'b000001}: code = 8'h54; // T
      {3'd2, 6'b000000}: code = 8'h49; // I
      {3'd2, 6'b000001}: code = 8'h41; // A
      {3'd2, 6'b000010}: code = 8'h4E; // N
      {3'd2, 6'b000011}: code = 8'h4D; // M
      {3'd3, 6'b000000}: code = 8'h53; // S
      {3'd3, 6'b000001}: code = 8'h55; // U
      {3'd3, 6'b000010}: code = 8'h52; // R
      {3'd3, 6'b000011}: code = 8'h57; // W
      {3'd3, 6'b000100}: code = 8'h44; // D
      {3'd3, 6'b000101}: code = 8'h4B; // K
      {3'd3, 6'b000110}: code = 8'h47; // G
      {3'd3, 6'b000111}: code = 8'h4F; // O
      {3'd4, 6'b000000}: code = 8'h48; // H
      {3'd4, 6'b000001}: code = 8'h56; // V
      {3'd4, 6'b000010}: code = 8'h46; // F
      {3'd4, 6'b000100}: code = 8'h4C; // L
      {3'd4, 6'b000110}: code = 8'h50; // P
      {3'd4, 6'b000111}: code = 8'h4A; // J
      {3'd4, 6'b001000}: code = 8'h42; // B
      {3'd4, 6'b001001}: code = 8'h58; // X
      {3'd4, 6'b001010}: code = 8'h43; // C
      {3'd4, 6'b001011}: code = 8'h59; // Y
      {3'd4, 6'b001100}: code = 8'h5A; // Z
      {3'd4, 6'b001101}: code = 8'h51; // Q
      {3'd5, 6'b011111}: code = 8'h30;
      {3'd5, 6'b001111}: code = 8'h31;
      {3'd5, 6'b000111}: code = 8'h32;
      {3'd5, 6'b000011}: code = 8'h33;
      {3'd5, 6'b000001}: code = 8'h34;
      {3'd5, 6'b000000}: code = 8'h35;
      {3'd5, 6'b010000}: code = 8'h36;
      {3'd5, 6'b011000}: code = 8'h37;
      {3'd5, 6'b011100}: code = 8'h38;
      {3'd5, 6'b011110}: code = 8'h39;
      {3'd5, 6'b010010}: code = 8'h2F; // /
      {3'd5, 6'b010001}: code = 8'h3D; // =
      {3'd6, 6'b010101}: code = 8'h2E; // .
      {3'd6, 6'b110011}: code = 8'h2C; // ,
      {3'd6, 6'b001100}: code = 8'h3F; // ?
      default:           code = 8'h3F;
    endcase
    return code;
  endfunction

  always_comb begin
    state_next     = state_reg;
    mark_cnt_next  = mark_cnt_reg;
    space_cnt_next = space_cnt_reg;
    pattern_next   = pattern_reg;
    count_next     = count_reg;
    emit           = 1'b0;
    emit_code      = 8'h00;
    if (disabled) begin
      state_next     = IDLE;
      mark_cnt_next  = '0;
      space_cnt_next = '0;
      pattern_next   = '0;
      count_next     = '0;
    end else if (bus.do1k) begin
      case (state_reg)
        IDLE: begin
          if (key_s_reg) begin
            state_next    = MARK;
            mark_cnt_next = CNT_W'(1);
          end
        end
        MARK: begin
          if (key_s_reg) begin
            mark_cnt_next = (mark_cnt_reg == CNT_MAX) ? mark_cnt_reg : mark_cnt_reg + CNT_W'(1);
          end else if (mark_cnt_reg < GLITCH_T) begin
            // Glitch: drop it, but keep any elements already collected.
            state_next     = (count_reg != 3'd0) ? SPACE : IDLE;
            space_cnt_next = CNT_W'(1);
          end else begin
            pattern_next   = {pattern_reg[4:0], (mark_cnt_reg >= dash_t)};
            count_next     = (count_reg == 3'd7) ? 3'd7 : count_reg + 3'd1;
            state_next     = SPACE;
            space_cnt_next = CNT_W'(1);
          end
        end
        SPACE, GAP: begin
          if (key_s_reg) begin
            state_next    = MARK;
            mark_cnt_next = CNT_W'(1);
          end else begin
            space_cnt_next = space_inc;
            if (state_reg == SPACE && space_inc >= char_t) begin
              emit         = 1'b1;
              emit_code    = lookup(count_reg, pattern_reg);
              pattern_next = '0;
              count_next   = '0;
              state_next   = GAP;
            end else if (state_reg == GAP && space_inc >= word_t) begin
              emit       = 1'b1;
              emit_code  = 8'h20;
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge IF_clk or negedge rstb) begin
    if (!rstb) begin
      key_meta_reg   <= 1'b0;
      key_s_reg      <= 1'b0;
      state_reg      <= IDLE;
      mark_cnt_reg   <= '0;
      space_cnt_reg  <= '0;
      pattern_reg    <= '0;
      count_reg      <= '0;
      char_code_reg  <= 8'h00;
      char_valid_reg <= 1'b0;
    end else begin
      key_meta_reg   <= bus.cw_key;
      key_s_reg      <= key_meta_reg;
      state_reg      <= state_next;
      mark_cnt_reg   <= mark_cnt_next;
      space_cnt_reg  <= space_cnt_next;
      pattern_reg    <= pattern_next;
      count_reg      <= count_next;
      char_valid_reg <= emit;
      if (emit) char_code_reg <= emit_code;
    end
  end

  assign bus.char_code  = char_code_reg;
  assign bus.char_valid = char_valid_reg;
  assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_cw_decoder.sv
// Directed-vector bench for cw_decoder: drives the key one 1 ms tick at a time
// and logs every strobe with its tick number for comparison with hand-computed results.
module tb_cw_decoder;

  logic IF_clk;
  logic rstb;
  cw_decoder_if bus();

  cw_decoder #(.GLITCH_MS(5), .CNT_W(13)) dut (
    .IF_clk (IF_clk),
    .rstb   (rstb),
    .bus    (bus)
  );

  initial IF_clk = 1'b0;
  always #5 IF_clk = ~IF_clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         tick_no = 0;
  logic [7:0] sq[$];
  int         st[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [31:0] code_at(input int i);
    return (i < sq.size()) ? 32'(sq[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] tick_at(input int i);
    return (i < st.size()) ? 32'(st[i]) : 32'hDEAD;
  endfunction

  // One 1 ms tick; entered and left on a falling edge. The key is set two edges
  // ahead so it has crossed the synchroniser when do1k is sampled.
  task automatic ms(input logic k);
    bus.cw_key = k;
    bus.do1k   = 1'b0;
    @(negedge IF_clk);
    @(negedge IF_clk);
    bus.do1k = 1'b1;
    @(negedge IF_clk);
    bus.do1k = 1'b0;
    tick_no++;
    if (bus.char_valid) begin
      sq.push_back(bus.char_code);
      st.push_back(tick_no);
    end
  endtask

  task automatic run(input logic k, input int n);
    for (int i = 0; i < n; i++) ms(k);
  endtask

  task automatic send(input string s, input int dt, input int tail);
    for (int i = 0; i < s.len(); i++) begin
      run(1'b1, (s[i] == 8'h2D) ? 3 * dt : dt);
      if (i != s.len() - 1) run(1'b0, dt);
    end
    run(1'b0, tail);
  endtask

  task automatic clear_log();
    sq.delete();
    st.delete();
  endtask

  int base;

  initial begin
    rstb          = 1'b0;
    bus.do1k      = 1'b0;
    bus.cw_key    = 1'b0;
    bus.dot_time  = 10'd60;
    bus.decode_en = 1'b1;
    repeat (3) @(negedge IF_clk);
    rstb = 1'b1;
    @(negedge IF_clk);

    check("reset char_code", 32'(bus.char_code), 32'h00);
    check("reset char_valid", 32'(bus.char_valid), 32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);

    // Baseline 'A' with word space.
    clear_log();
    run(1'b1, 60); run(1'b0, 60); run(1'b1, 180);
    base = tick_no;
    run(1'b0, 300);
    check("A strobes", 32'(sq.size()), 32'd2);
    check("A code", code_at(0), 32'h41);
    check("A tick", tick_at(0) - 32'(base), 32'd120);
    check("A space code", code_at(1), 32'h20);
    check("A space tick", tick_at(1) - 32'(base), 32'd300);
    check("A busy after", 32'(bus.busy), 32'h0);

    // Dash/dot boundary at 2*dot_time.
    clear_log();
    run(1'b1, 119); run(1'b0, 310);
    check("119ms strobes", 32'(sq.size()), 32'd2);
    check("119ms code E", code_at(0), 32'h45);
    clear_log();
    run(1'b1, 120); run(1'b0, 310);
    check("120ms strobes", 32'(sq.size()), 32'd2);
    check("120ms code T", code_at(0), 32'h54);

    // Inter-element space of 119 ms must not split the character.
    clear_log();
    run(1'b1, 60); run(1'b0, 119); run(1'b1, 60); run(1'b0, 310);
    check("space119 strobes", 32'(sq.size()), 32'd2);
    check("space119 code I", code_at(0), 32'h49);

    // Glitch from IDLE.
    clear_log();
    run(1'b1, 3);
    check("glitch busy in mark", 32'(bus.busy), 32'h1);
    run(1'b0, 1);
    check("glitch busy idle", 32'(bus.busy), 32'h0);
    run(1'b0, 310);
    check("glitch no strobe", 32'(sq.size()), 32'd0);

    // Glitch inside the space after 'E'.
    clear_log();
    run(1'b1, 60); run(1'b0, 50); run(1'b1, 3); run(1'b0, 310);
    check("space glitch strobes", 32'(sq.size()), 32'd2);
    check("space glitch code E", code_at(0), 32'h45);

    // Unknown pattern, overflow, recovery (dot_time 20).
    bus.dot_time = 10'd20;
    clear_log();
    send("......", 20, 110);
    check("6 dots strobes", 32'(sq.size()), 32'd2);
    check("6 dots code", code_at(0), 32'h3F);
    clear_log();
    send(".......", 20, 110);
    check("7 dots strobes", 32'(sq.size()), 32'd2);
    check("7 dots code", code_at(0), 32'h3F);
    clear_log();
    send("-.-", 20, 110);
    check("K strobes", 32'(sq.size()), 32'd2);
    check("K code", code_at(0), 32'h4B);

    // Disable mid-character: char_code held, no strobe.
    clear_log();
    send("-.-", 20, 50);
    check("K2 code", code_at(0), 32'h4B);
    clear_log();
    run(1'b1, 20); run(1'b0, 20); run(1'b1, 20);
    bus.decode_en = 1'b0;
    run(1'b0, 5);
    check("disable busy", 32'(bus.busy), 32'h0);
    bus.decode_en = 1'b1;
    run(1'b0, 120);
    check("disable no strobe", 32'(sq.size()), 32'd0);
    check("disable code held", 32'(bus.char_code), 32'h4B);

    // Asynchronous reset mid-character.
    clear_log();
    run(1'b1, 20); run(1'b0, 20); run(1'b1, 20); run(1'b0, 5);
    check("pre-reset busy", 32'(bus.busy), 32'h1);
    #2 rstb = 1'b0;
    #1;
    check("mid reset char_code", 32'(bus.char_code), 32'h00);
    check("mid reset char_valid", 32'(bus.char_valid), 32'h0);
    check("mid reset busy", 32'(bus.busy), 32'h0);
    @(negedge IF_clk);
    rstb = 1'b1;
    run(1'b0, 120);
    check("post reset no strobe", 32'(sq.size()), 32'd0);

    // 10 s key: saturated counter stays above DASH_T=2000; a wrap would leave 1808.
    bus.dot_time = 10'd1000;
    clear_log();
    run(1'b1, 10000); run(1'b0, 2010);
    check("long key strobes", 32'(sq.size()), 32'd1);
    check("long key code T", code_at(0), 32'h54);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cw_decoder.md
Name: cw_decoder

Overview:
- Receive-side counterpart of the iambic keyer. Measures mark/space durations of a keyed CW signal in 1 ms ticks and classifies elements as dot or dash.
- Assembles up to 6 elements per character and emits one ASCII byte per character, plus 0x20 on a word gap.
- Sits in the IF_clk domain. Shares the keyer's 1 ms tick (do1k) and its WPM-derived dot time. Its output feeds the control/status path to the host.

Parameters:
- GLITCH_MS, 5, marks shorter than this many ms are discarded.
- CNT_W, 13, width of the mark/space counters; counters saturate at 2^CNT_W-1.

Ports:
- IF_clk  in  1  system clock (48 MHz)
- rstb  in  1  asynchronous, active-low reset
- do1k  in  1  one-IF_clk-cycle pulse every 1 ms
- cw_key  in  1  keyed signal, active high, asynchronous to IF_clk
- dot_time  in  10  nominal dot duration in ms; 0 = decoder disabled
- decode_en  in  1  1 = decode, 0 = forced idle
- char_code  out  8  ASCII of last decoded character
- char_valid  out  1  one-cycle strobe, char_code valid
- busy  out  1  high when state != IDLE

Behaviour:
- Reset values: char_code=0x00, char_valid=0, busy=0, state=IDLE, element count=0, pattern=0, counters=0. Reset is asynchronous and legal mid-character; no emission follows it.
- Input synchronisation: cw_key passes through a 2-flop synchroniser (key_s). All state updates occur only on IF_clk cycles with do1k=1, using the key_s value from that cycle.
- Thresholds, computed combinationally from dot_time:
  - DASH_T = 2*dot_time
  - CHAR_T = 2*dot_time
  - WORD_T = 5*dot_time
  - All thresholds are zero-extended to CNT_W.
- Element store:
  - 6-bit pattern register, shift-left; each new element enters bit0 (1 = dash).
  - 3-bit element count, saturating at 7; a count of 7 means overflow.
- FSM states and transitions (all on do1k ticks):
  - IDLE: key_s=1 → MARK, mark_cnt=1.
  - MARK, key_s=1: mark_cnt increments, saturating.
  - MARK, key_s=0, mark_cnt < GLITCH_MS: mark is discarded. Go to SPACE with space_cnt=1 if count > 0, else go to IDLE.
  - MARK, key_s=0, otherwise: append a dash if mark_cnt >= DASH_T, else a dot. Increment count. Go to SPACE, space_cnt=1.
  - SPACE, key_s=1: → MARK, mark_cnt=1. Elements are kept.
  - SPACE, key_s=0: space_cnt increments. When space_cnt reaches CHAR_T, emit the character, clear pattern and count, and go to GAP.
  - GAP, key_s=1: → MARK, mark_cnt=1.
  - GAP, key_s=0: space_cnt increments. When space_cnt reaches WORD_T, emit 0x20 and go to IDLE.
  - Only one space is ever emitted per gap, and only after a character.
- Emission:
  - char_code and char_valid are registered.
  - char_valid=1 for exactly one IF_clk cycle, on the cycle after the qualifying do1k cycle.
  - char_code holds its value until the next emission.
  - There is no backpressure; the consumer must sample on the strobe.
- Lookup, keyed on (count, pattern):
  - A–Z → 0x41–0x5A
  - 0–9 → 0x30–0x39
  - '.' .-.-.- → 0x2E
  - ',' --..-- → 0x2C
  - '?' ..--.. → 0x3F
  - '/' -..-. → 0x2F
  - '=' -...- → 0x3D
  - Any unlisted pattern, and count=7 (overflow), emit 0x3F.
- Disable: decode_en=0 or dot_time=0 forces state=IDLE and clears counters and pattern at the next IF_clk edge. No emission occurs; char_code is held.
- Mid-operation dot_time change: takes effect on the next comparison; no restart.
- busy = (state != IDLE).

Test Plan:
- Baseline "A": dot_time=60, decode_en=1. Key high 60 ms, low 60 ms, high 180 ms, then low → char_valid with char_code=0x41 at the 120th low tick. Then char_valid with 0x20 at the 300th low tick. busy=0 afterwards.
- Dash/dot boundary: dot_time=60, single mark of 119 ms → 0x45 ('E'). Single mark of 120 ms → 0x54 ('T').
- Space boundary: dot_time=60. Mark 60 ms, space 119 ms, mark 60 ms, then idle → one strobe 0x49 ('I'), not two 'E's.
- Glitch: from IDLE, 3 ms pulse → no strobe, busy returns to 0. 3 ms pulse inside the space of 'E' → single 0x45 with no extra element.
- Unknown and overflow: six dots → 0x3F. Seven dots → 0x3F. Next character "-.-" decodes as 0x4B.
- Reset/disable mid-character: after two dots, pulse rstb low → char_code=0x00, char_valid=0, busy=0, no later strobe. Repeat with decode_en=0 → no strobe, char_code unchanged. Key held 10 s → single 0x54 with counter saturation and no wrap.
